// File: rtl/dc_fifo_read_ctrl_pkg.sv
// Shared helpers for the dual-clock FIFO controllers (read and write side).
// Vector helpers operate on MAX_DEPTH-wide values; callers zero-extend in
// and truncate out, so any BUFFER_DEPTH up to MAX_DEPTH is supported.
package dc_fifo_read_ctrl_pkg;
  localparam int MAX_DEPTH = 64;

  // Ceiling log2; usable in parameter and port-width expressions.
  function automatic int log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic logic [MAX_DEPTH-1:0] rot_left(input logic [MAX_DEPTH-1:0] v,
                                                    input int n);
    logic [MAX_DEPTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DEPTH; i++)
      if (i < n) r[(i + 1) % n] = v[i];
    return r;
  endfunction

  // Number of set bits.
  function automatic int popcount(input logic [MAX_DEPTH-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_DEPTH; i++) c += int'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/dc_fifo_read_ctrl_if.sv
// Registered valid/ready output stream of the FIFO read controller.
interface dc_fifo_read_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dc_fifo_read_ctrl_sync_2ff.sv
// Per-bit two-flop synchronizer. Only safe for vectors whose bits change
// at most once per sampling window (toggle vectors), not for binary counts.
module dc_sync_2ff #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  // Two-stage capture of the foreign-domain vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/dc_fifo_read_ctrl.sv
// Consumer-domain read controller for the one-hot indexed dual-clock FIFO.
// Occupancy per entry is the XOR of the synchronized write toggle and the
// local read toggle; the output register acts as the EMPTY/HOLD state.
module dc_fifo_read_ctrl
  import dc_fifo_read_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [BUFFER_DEPTH-1:0]   write_toggle,
  output logic [BUFFER_DEPTH-1:0]   read_toggle,
  output logic [BUFFER_DEPTH-1:0]   read_pointer,
  input  logic [DATA_WIDTH-1:0]     read_data,
  output logic [log2(BUFFER_DEPTH):0] fill_o,
  dc_fifo_read_ctrl_if.master       strm
);
  localparam int FILL_W = log2(BUFFER_DEPTH) + 1;

  logic [BUFFER_DEPTH-1:0] wtog_s;
  logic [BUFFER_DEPTH-1:0] read_toggle_next;
  logic [BUFFER_DEPTH-1:0] pointer_next;
  logic                    avail;
  logic                    load;

  dc_sync_2ff #(.WIDTH(BUFFER_DEPTH)) u_wtog_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (write_toggle),
    .q    (wtog_s)
  );

  // Pop decision: head entry occupied and output register free or draining.
  always_comb begin
    avail            = |((wtog_s ^ read_toggle) & read_pointer);
    load             = avail & (~strm.valid | strm.ready);
    read_toggle_next = load ? (read_toggle ^ read_pointer) : read_toggle;
    pointer_next     = BUFFER_DEPTH'(rot_left(MAX_DEPTH'(read_pointer), BUFFER_DEPTH));
  end

  // Output register, pointer, toggle and fill count; read_toggle has no
  // combinational path from ready so the write side can synchronize it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      read_pointer <= BUFFER_DEPTH'(1);
      read_toggle  <= '0;
      strm.valid   <= 1'b0;
      strm.data    <= '0;
      fill_o       <= '0;
    end else begin
      read_toggle <= read_toggle_next;
      fill_o      <= FILL_W'(popcount(MAX_DEPTH'(wtog_s ^ read_toggle_next)));
      if (load) begin
        strm.data    <= read_data;
        strm.valid   <= 1'b1;
        read_pointer <= pointer_next;
      end else if (strm.ready) begin
        strm.valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/dc_fifo_read_ctrl.md
# dc_fifo_read_ctrl

Read-side controller for the dual-clock FIFO in the AXI clock-domain-crossing slice. Sits in the consumer clock domain beside the one-hot-indexed data buffer. Drives the buffer's one-hot `read_pointer`, samples the buffer's combinational `read_data`, and detects occupancy from a per-entry toggle vector sent by the write side. Presents a registered valid/ready stream to the consumer and returns its own toggle vector to the write domain for full detection.

## Interface
- `DATA_WIDTH`, 32: payload width; matches the data buffer.
- `BUFFER_DEPTH`, 8: number of entries; power of two, ≥2; one-hot pointer width.
- `clk`  in  1  consumer-domain clock.
- `rstn`  in  1  reset: asynchronous, active-low.
- `write_toggle`  in  BUFFER_DEPTH  write-domain toggle vector; bit i flips when entry i is written; asynchronous to `clk`.
- `read_toggle`  out  BUFFER_DEPTH  registered; bit i flips when entry i is popped; sent to the write domain.
- `read_pointer`  out  BUFFER_DEPTH  registered one-hot index of the next entry to pop; drives the buffer.
- `read_data`  in  DATA_WIDTH  buffer contents at `read_pointer`; combinational from the buffer.
- `valid_o`  out  1  `data_o` holds a word.
- `ready_i`  in  1  consumer accepts `data_o`.
- `data_o`  out  DATA_WIDTH  registered output word.
- `fill_o`  out  log2(BUFFER_DEPTH)+1  registered count of occupied buffer entries; excludes the output register.

## Operation
- Synchronizer: `write_toggle` passes through two flops to give `wtog_s`. Each bit changes at most once per write, so per-bit synchronization is safe. The write side updates the data entry no later than the toggle, so buffer data is stable whenever `wtog_s` shows the entry occupied.
- Entry i is occupied when `wtog_s[i] != read_toggle[i]`.
- `avail` = entry at `read_pointer` is occupied, i.e. `|((wtog_s ^ read_toggle) & read_pointer)`.
- `load` = `avail & (~valid_o | ready_i)`.
- On `load`:
  - `data_o <= read_data`; `valid_o <= 1`.
  - `read_toggle <= read_toggle ^ read_pointer`.
  - `read_pointer` rotates left by one; the MSB wraps to bit 0.
- On `valid_o & ready_i & ~avail`: `valid_o <= 0`; `data_o` holds its last value.
- With `valid_o=1` and `ready_i=0`: `data_o`, `read_pointer` and `read_toggle` are held.
- `fill_o <= popcount(wtog_s ^ read_toggle_next)`, where `read_toggle_next` is the value being registered this cycle. Range is 0..BUFFER_DEPTH.
- Reset values:
  - `read_pointer` = 1 (entry 0).
  - `read_toggle`, both synchronizer stages, `data_o`, `fill_o` = 0.
  - `valid_o` = 0.
- Reset mid-operation: all state returns to reset values immediately. Both domains are reset together by system convention; any words in flight are discarded. No `valid_o` glitch occurs on reset deassertion.
- The block has no explicit FSM. The implicit state is the output register: EMPTY (`valid_o=0`) and HOLD (`valid_o=1`).
  - EMPTY→HOLD on `load`.
  - HOLD→HOLD on `load`, or when stalled.
  - HOLD→EMPTY on `ready_i & ~avail`.

## Timing
- Write-side toggle edge to `valid_o` high: 3 `clk` rising edges worst case (2 sync + 1 load), plus up to one cycle of CDC sampling uncertainty.
- Full throughput: with `ready_i` held high and `avail` true, one word is popped per cycle.
- Simultaneous handshake and load: the new word replaces the accepted word in the same edge; no bubble.
- Wrap-around: pointer 8'b1000_0000 advances to 8'b0000_0001; toggle bits handle the lap count, so full and empty are never ambiguous.
- `read_toggle` is registered with no combinational path from `ready_i`, so it is safe to synchronize in the write domain.

## Structure
- A shared `dc_fifo` include/package holds:
  - the `log2` constant function;
  - the pointer-rotate and popcount helper functions, shared with the write-side controller.
- One sub-module, `dc_sync_2ff`: a parameterized-width two-flop synchronizer with async active-low reset to 0. The write side reuses it for `read_toggle`.

## Test plan
All scenarios use BUFFER_DEPTH=8, DATA_WIDTH=32.
1. Reset: assert `rstn=0` mid-stream → `read_pointer`=8'h01, `read_toggle`=0, `valid_o`=0, `fill_o`=0 within the same cycle; all outputs hold after release.
2. Single word: buffer entry 0 = 32'hDEADBEEF, flip `write_toggle[0]`, `ready_i=1` → `valid_o` rises on the 3rd edge with `data_o`=32'hDEADBEEF; then `read_toggle`=8'h01 and `read_pointer`=8'h02.
3. Burst and wrap: write 10 words 0..9 (toggles 8'hFF, then bits 0 and 1 flip back), `ready_i=1` → `data_o` sequence 0..9 with no gaps after the first; pointer returns to 8'h04; final `read_toggle`=8'hFC.
4. Backpressure: 8 words written, `ready_i=0` → `valid_o`=1 holding word 0, `fill_o`=7, pointer=8'h02. Release `ready_i` → words 1..7 arrive on consecutive cycles, then `valid_o`=0 and `fill_o`=0.
5. Simultaneous accept and arrival: `valid_o=1`, `ready_i=1`, next entry becoming occupied on the same edge → new word loads with no idle cycle; `valid_o` stays 1.
6. Random CDC: write clock at 1.7× `clk`, random `ready_i`, 10k words → in-order, no loss or duplication, `fill_o`≤8 always.
